bp_me_acc_result_sink: RTL and testbench

Memory-side responder for the BedRock memory-forward stream emitted by the tensor accelerator pipe. It accepts streamed uncached writes (and reads), stores result blocks in a small flop-based result buffer, and returns BedRock memory-reverse responses. Completed 64-byte block writes are signalled to local logic with an entry index. It sits on the accelerator's mem_fwd/mem_rev link in place of a generic memory endpoint.

---
 rtl/bp_me_acc_result_sink.sv | 173 +++++++++++++++++
 tb/tb_bp_me_acc_result_sink.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_acc_result_sink.sv
// BedRock mem_fwd/mem_rev endpoint holding accelerator result blocks.
// Define BP_ME_ACC_RESULT_SINK_READBACK_EN to return stored data on uc_rd.
module bp_me_acc_result_sink
  #(parameter int paddr_width_p = 40
  , parameter int bedrock_fill_width_p = 64
  , parameter int payload_width_p = 16
  , parameter int els_p = 16
  , localparam int lg_els_lp = $clog2(els_p)
  , localparam int mem_fwd_header_width_lp = payload_width_p + paddr_width_p + 11
  , localparam int mem_rev_header_width_lp = mem_fwd_header_width_lp
  )
  (input  logic                               clk_i
  , input  logic                               reset_i
  , input  logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_i
  , input  logic [bedrock_fill_width_p-1:0]    mem_fwd_data_i
  , input  logic                               mem_fwd_v_i
  , output logic                               mem_fwd_ready_and_o
  , output logic [mem_rev_header_width_lp-1:0] mem_rev_header_o
  , output logic [bedrock_fill_width_p-1:0]    mem_rev_data_o
  , output logic                               mem_rev_v_o
  , input  logic                               mem_rev_ready_and_i
  , output logic                               done_v_o
  , output logic [lg_els_lp-1:0]               done_idx_o
  , output logic [15:0]                        write_count_o
  , output logic                               error_o
  );

  localparam int fb_lp = bedrock_fill_width_p / 8;
  localparam int lg_fb_lp = $clog2(fb_lp);
  localparam int bpb_lp = 512 / bedrock_fill_width_p;
  localparam int lg_bpb_lp = $clog2(bpb_lp);
  localparam int addr_lsb_lp = 8;
  localparam int size_lsb_lp = 8 + paddr_width_p;
  localparam logic [3:0] uc_rd_lp = 4'd2;
  localparam logic [3:0] uc_wr_lp = 4'd3;
  localparam logic [2:0] size_64_lp = 3'd6;

  typedef enum logic [1:0] {e_ready, e_recv, e_resp} state_e;

  function automatic logic [8:0] msg_beats(input logic [2:0] sz);
    logic [8:0] r;
    if (int'(sz) > lg_fb_lp) r = 9'd1 << (int'(sz) - lg_fb_lp);
    else r = 9'd1;
    return r;
  endfunction

  function automatic logic [fb_lp-1:0] byte_mask
    (input logic [2:0] sz, input logic [lg_fb_lp-1:0] off);
    logic [fb_lp-1:0] m;
    if (int'(sz) >= lg_fb_lp) m = '1;
    else m = ((fb_lp'(1) << (1 << sz)) - fb_lp'(1)) << off;
    return m;
  endfunction

  state_e state_q, state_d;
  logic [mem_fwd_header_width_lp-1:0] hdr_q, hdr_d;
  logic [8:0] cnt_q, cnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic err_q, err_d;
  logic [bedrock_fill_width_p-1:0] mem_q [els_p][bpb_lp];

  logic first;
  logic [3:0] cur_type;
  logic [2:0] cur_size;
  logic [lg_els_lp-1:0] cur_entry;
  logic [lg_bpb_lp-1:0] cur_slot0, wr_slot;
  logic [lg_fb_lp-1:0] cur_off;
  logic [8:0] beat_idx, cur_beats, rsp_beats;
  logic [fb_lp-1:0] wr_mask;
  logic is_wr, is_rd, rsp_is_rd;
  logic fwd_xfer, fwd_last, wr_en, rev_xfer, rev_last;

  // Header fields come straight off the bus on the first beat.
  assign first = (state_q == e_ready);
  assign cur_type = first ? mem_fwd_header_i[3:0] : hdr_q[3:0];
  assign cur_size = first ? mem_fwd_header_i[size_lsb_lp +: 3]
                          : hdr_q[size_lsb_lp +: 3];
  assign cur_entry = first ? mem_fwd_header_i[addr_lsb_lp+6 +: lg_els_lp]
                           : hdr_q[addr_lsb_lp+6 +: lg_els_lp];
  assign cur_slot0 = first ? mem_fwd_header_i[addr_lsb_lp+lg_fb_lp +: lg_bpb_lp]
                           : hdr_q[addr_lsb_lp+lg_fb_lp +: lg_bpb_lp];
  assign cur_off = first ? mem_fwd_header_i[addr_lsb_lp +: lg_fb_lp]
                         : hdr_q[addr_lsb_lp +: lg_fb_lp];

  assign beat_idx = first ? 9'd0 : cnt_q;
  assign cur_beats = msg_beats(cur_size);
  assign is_wr = (cur_type == uc_wr_lp);
  assign is_rd = (cur_type == uc_rd_lp);
  assign wr_slot = cur_slot0 + beat_idx[lg_bpb_lp-1:0];
  assign wr_mask = byte_mask(cur_size, cur_off);

  assign mem_fwd_ready_and_o = ~reset_i & (state_q != e_resp);
  assign fwd_xfer = mem_fwd_ready_and_o & mem_fwd_v_i;
  assign fwd_last = (beat_idx == cur_beats - 9'd1);
  assign wr_en = fwd_xfer & is_wr;

  assign rsp_is_rd = (hdr_q[3:0] == uc_rd_lp);
  assign rsp_beats = rsp_is_rd ? msg_beats(hdr_q[size_lsb_lp +: 3]) : 9'd1;
  assign rev_xfer = (state_q == e_resp) & mem_rev_ready_and_i;
  assign rev_last = (cnt_q == rsp_beats - 9'd1);

  always_comb begin
    state_d = state_q;
    hdr_d = hdr_q;
    cnt_d = cnt_q;
    wcnt_d = wcnt_q;
    err_d = err_q;
    unique case (state_q)
      e_ready: if (fwd_xfer) begin
        hdr_d = mem_fwd_header_i;
        cnt_d = fwd_last ? 9'd0 : 9'd1;
        state_d = fwd_last ? e_resp : e_recv;
        err_d = err_q | (~is_wr & ~is_rd);
      end
      e_recv: if (fwd_xfer) begin
        cnt_d = fwd_last ? 9'd0 : cnt_q + 9'd1;
        state_d = fwd_last ? e_resp : e_recv;
      end
      e_resp: if (rev_xfer) begin
        cnt_d = rev_last ? 9'd0 : cnt_q + 9'd1;
        state_d = rev_last ? e_ready : e_resp;
      end
      default: state_d = e_ready;
    endcase
    if (wr_en & fwd_last) wcnt_d = wcnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      hdr_q <= '0;
      cnt_q <= '0;
      wcnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q <= hdr_d;
      cnt_q <= cnt_d;
      wcnt_q <= wcnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en)
      for (int b = 0; b < fb_lp; b++)
        if (wr_mask[b])
          mem_q[cur_entry][wr_slot][8*b +: 8] <= mem_fwd_data_i[8*b +: 8];
  end

  assign done_v_o = wr_en & fwd_last & (cur_size == size_64_lp);
  assign done_idx_o = cur_entry;
  assign write_count_o = wcnt_q;
  assign error_o = err_q;
  assign mem_rev_v_o = (state_q == e_resp);
  assign mem_rev_header_o = hdr_q;

`ifdef BP_ME_ACC_RESULT_SINK_READBACK_EN
  logic [lg_els_lp-1:0] rd_entry;
  logic [lg_bpb_lp-1:0] rd_slot;
  assign rd_entry = hdr_q[addr_lsb_lp+6 +: lg_els_lp];
  assign rd_slot = hdr_q[addr_lsb_lp+lg_fb_lp +: lg_bpb_lp]
                 + cnt_q[lg_bpb_lp-1:0];
  assign mem_rev_data_o = (mem_rev_v_o & rsp_is_rd)
                        ? mem_q[rd_entry][rd_slot] : '0;
`else
  // Without readback the buffer is only consumed by local logic.
  logic [bedrock_fill_width_p-1:0] unused_storage;
  assign unused_storage = mem_q[0][0];
  assign mem_rev_data_o = '0;
`endif

endmodule

// File: tb/tb_bp_me_acc_result_sink.sv
// Directed bench for bp_me_acc_result_sink.
// Read-data expectations follow BP_ME_ACC_RESULT_SINK_READBACK_EN.
module tb_bp_me_acc_result_sink;

  localparam int HW = 16 + 40 + 11;
`ifdef BP_ME_ACC_RESULT_SINK_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i;
  logic [HW-1:0] mem_fwd_header_i;
  logic [63:0] mem_fwd_data_i;
  logic mem_fwd_v_i;
  logic mem_fwd_ready_and_o;
  logic [HW-1:0] mem_rev_header_o;
  logic [63:0] mem_rev_data_o;
  logic mem_rev_v_o;
  logic mem_rev_ready_and_i;
  logic done_v_o;
  logic [3:0] done_idx_o;
  logic [15:0] write_count_o;
  logic error_o;

  bp_me_acc_result_sink dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .mem_fwd_header_i(mem_fwd_header_i),
    .mem_fwd_data_i(mem_fwd_data_i),
    .mem_fwd_v_i(mem_fwd_v_i),
    .mem_fwd_ready_and_o(mem_fwd_ready_and_o),
    .mem_rev_header_o(mem_rev_header_o),
    .mem_rev_data_o(mem_rev_data_o),
    .mem_rev_v_o(mem_rev_v_o),
    .mem_rev_ready_and_i(mem_rev_ready_and_i),
    .done_v_o(done_v_o),
    .done_idx_o(done_idx_o),
    .write_count_o(write_count_o),
    .error_o(error_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt;
  logic [3:0] done_idx_seen;
  logic [63:0] fwd_data [16];
  logic [63:0] rsp_exp [16];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] mt,
    input logic [39:0] addr, input logic [2:0] sz, input logic [15:0] pl);
    return {pl, sz, addr, 4'h2, mt};
  endfunction

  task automatic send_msg(input string tag, input logic [HW-1:0] h,
                          input int n);
    int stalls;
    int t;
    stalls = 0;
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      mem_fwd_header_i = h;
      mem_fwd_data_i = fwd_data[i];
      mem_fwd_v_i = 1'b1;
      #1;
      t = 0;
      while (!mem_fwd_ready_and_o && t < 20) begin
        @(posedge clk); #1; t++;
      end
      stalls += t;
      if (done_v_o) begin
        done_cnt++;
        done_idx_seen = done_idx_o;
      end
      @(posedge clk); #1;
    end
    mem_fwd_v_i = 1'b0;
    mem_fwd_data_i = '0;
    check({tag, "_stall"}, stalls, 0);
  endtask

  task automatic recv_rsp(input string tag, input logic [HW-1:0] h,
                          input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!mem_rev_v_o && t < 20) begin
        @(posedge clk); #1; t++;
      end
      check({tag, "_lat"}, t, 0);
      check({tag, "_hdr"}, mem_rev_header_o, h);
      check({tag, "_data"}, mem_rev_data_o, rsp_exp[k]);
      @(posedge clk); #1;
    end
    check({tag, "_vend"}, mem_rev_v_o, 0);
    check({tag, "_rdy"}, mem_fwd_ready_and_o, 1);
  endtask

  logic [HW-1:0] h;

  initial begin
    reset_i = 1'b1;
    mem_fwd_header_i = '0;
    mem_fwd_data_i = '0;
    mem_fwd_v_i = 1'b0;
    mem_rev_ready_and_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", mem_fwd_ready_and_o, 0);
    check("rst_revv", mem_rev_v_o, 0);
    check("rst_done", done_v_o, 0);
    check("rst_wcnt", write_count_o, 0);
    check("rst_err", error_o, 0);
    reset_i = 1'b0;
    #1;
    check("rst_rdy_after", mem_fwd_ready_and_o, 1);

    // 64 B write, entry 7
    h = mk_hdr(4'd3, 40'h1C0, 3'd6, 16'h1234);
    for (int i = 0; i < 8; i++) fwd_data[i] = 64'(i);
    send_msg("wr1c0", h, 8);
    check("wr1c0_done", done_cnt, 1);
    check("wr1c0_idx", done_idx_seen, 7);
    rsp_exp[0] = '0;
    recv_rsp("wr1c0_rsp", h, 1);
    check("wr1c0_wcnt", write_count_o, 1);

    // critical-word-first write then aligned read, entry 2
    h = mk_hdr(4'd3, 40'h0A8, 3'd6, 16'h0002);
    for (int i = 0; i < 8; i++) fwd_data[i] = 64'hA0 + 64'(i);
    send_msg("wr0a8", h, 8);
    check("wr0a8_idx", done_idx_seen, 2);
    rsp_exp[0] = '0;
    recv_rsp("wr0a8_rsp", h, 1);
    h = mk_hdr(4'd2, 40'h080, 3'd6, 16'h0003);
    for (int i = 0; i < 8; i++) fwd_data[i] = '0;
    send_msg("rd080", h, 8);
    check("rd080_done", done_cnt, 0);
    for (int k = 0; k < 8; k++)
      rsp_exp[k] = RB ? 64'hA0 + 64'((k + 3) % 8) : 64'h0;
    mem_rev_ready_and_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("hold_v", mem_rev_v_o, 1);
      check("hold_hdr", mem_rev_header_o, h);
      check("hold_data", mem_rev_data_o, rsp_exp[0]);
      check("hold_fwdrdy", mem_fwd_ready_and_o, 0);
      @(posedge clk); #1;
    end
    mem_rev_ready_and_i = 1'b1;
    recv_rsp("rd080_rsp", h, 8);
    check("rd080_wcnt", write_count_o, 2);

    // partial-width write merges into an 8 B slot, entry 4
    h = mk_hdr(4'd3, 40'h100, 3'd3, 16'h0004);
    fwd_data[0] = 64'h1111_1111_2222_2222;
    send_msg("wr8", h, 1);
    check("wr8_done", done_cnt, 0);
    rsp_exp[0] = '0;
    recv_rsp("wr8_rsp", h, 1);
    h = mk_hdr(4'd3, 40'h104, 3'd2, 16'h0005);
    fwd_data[0] = 64'hDEAD_BEEF_CAFE_F00D;
    send_msg("wr4", h, 1);
    check("wr4_done", done_cnt, 0);
    recv_rsp("wr4_rsp", h, 1);
    h = mk_hdr(4'd2, 40'h100, 3'd3, 16'h0006);
    fwd_data[0] = '0;
    send_msg("rd8", h, 1);
    rsp_exp[0] = RB ? 64'hDEAD_BEEF_2222_2222 : 64'h0;
    recv_rsp("rd8_rsp", h, 1);
    check("rd8_wcnt", write_count_o, 4);

    // unsupported amo, 16 B = 2 beats
    h = mk_hdr(4'd5, 40'h1C0, 3'd4, 16'h0007);
    fwd_data[0] = 64'hBAD0;
    fwd_data[1] = 64'hBAD1;
    send_msg("amo", h, 2);
    check("amo_done", done_cnt, 0);
    rsp_exp[0] = '0;
    recv_rsp("amo_rsp", h, 1);
    check("amo_err", error_o, 1);
    check("amo_wcnt", write_count_o, 4);
    h = mk_hdr(4'd2, 40'h1C0, 3'd6, 16'h0008);
    for (int i = 0; i < 8; i++) fwd_data[i] = '0;
    send_msg("rd1c0", h, 8);
    for (int k = 0; k < 8; k++) rsp_exp[k] = RB ? 64'(k) : 64'h0;
    recv_rsp("rd1c0_rsp", h, 8);
    check("amo_err_sticky", error_o, 1);

    // reset after 3 of 8 write beats
    h = mk_hdr(4'd3, 40'h1C0, 3'd6, 16'h0009);
    for (int i = 0; i < 8; i++) fwd_data[i] = 64'h50 + 64'(i);
    send_msg("part", h, 3);
    check("part_done", done_cnt, 0);
    check("part_revv", mem_rev_v_o, 0);
    reset_i = 1'b1;
    #1;
    check("part_rst_rdy", mem_fwd_ready_and_o, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("part_rst_revv", mem_rev_v_o, 0);
    check("part_rst_wcnt", write_count_o, 0);
    check("part_rst_err", error_o, 0);
    reset_i = 1'b0;
    #1;
    check("part_rdy", mem_fwd_ready_and_o, 1);
    check("part_norsp", mem_rev_v_o, 0);
    h = mk_hdr(4'd3, 40'h000, 3'd6, 16'h000A);
    for (int i = 0; i < 8; i++) fwd_data[i] = 64'h60 + 64'(i);
    send_msg("wr000", h, 8);
    check("wr000_done", done_cnt, 1);
    check("wr000_idx", done_idx_seen, 0);
    rsp_exp[0] = '0;
    recv_rsp("wr000_rsp", h, 1);
    check("wr000_wcnt", write_count_o, 1);
    h = mk_hdr(4'd2, 40'h1C0, 3'd6, 16'h000B);
    for (int i = 0; i < 8; i++) fwd_data[i] = '0;
    send_msg("rdpart", h, 8);
    for (int k = 0; k < 8; k++)
      rsp_exp[k] = !RB ? 64'h0 : (k < 3) ? 64'h50 + 64'(k) : 64'(k);
    recv_rsp("rdpart_rsp", h, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
